// File: rtl/intersection_sched.sv
// intersection_sched: tick prescaler and run/all-red sequencer for the intersection lights
module intersection_sched #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int MAINT_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       emergency,
  output logic       tick,
  output logic       run,
  output logic       all_red,
  output logic [6:0] cycle_cnt,
  output logic       cycle_wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(MAINT_HOLD + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HLOAD = HW'(MAINT_HOLD);
  localparam logic [6:0] LAST = 7'd68;
  typedef enum logic [2:0] {IDLE, SYNC, RUN, CLEAR, HOLD} state_t;
  state_t state, state_d;
  logic [PW-1:0] pre, pre_d;
  logic [HW-1:0] hold, hold_d;
  logic [6:0] cnt_d;
  logic stop, stop_d, wrap_d;
  assign pre_d = pre == PMAX ? '0 : pre + 1'b1;
  // Free-running prescaler; tick is registered so it lines up with pre == TICK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= pre_d;
      tick <= pre_d == PMAX;
    end
  end
  // Next-state: emergency pre-empts everything, otherwise transitions wait for tick
  always_comb begin
    state_d = state;
    cnt_d   = cycle_cnt;
    stop_d  = stop;
    hold_d  = hold;
    wrap_d  = 1'b0;
    if (emergency) begin
      state_d = CLEAR;
      cnt_d   = '0;
      stop_d  = 1'b0;
    end else begin
      case (state)
        IDLE: if (tick && enable) state_d = SYNC;
        SYNC: if (tick) begin
          state_d = RUN;
          cnt_d   = 7'd1;
        end
        RUN: if (tick) begin
          if (cycle_cnt == LAST && stop && !enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            stop_d  = 1'b0;
          end else begin
            cnt_d  = cycle_cnt == LAST ? 7'd1 : cycle_cnt + 7'd1;
            wrap_d = cycle_cnt == LAST;
            stop_d = !enable;
          end
        end
        CLEAR: begin
          state_d = HOLD;
          hold_d  = HLOAD;
        end
        HOLD: if (tick) begin
          hold_d = hold - 1'b1;
          if (hold == HW'(1)) state_d = enable ? SYNC : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // State and registered outputs, all decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      stop       <= 1'b0;
      hold       <= '0;
      cycle_wrap <= 1'b0;
      run        <= 1'b0;
      all_red    <= 1'b1;
    end else begin
      state      <= state_d;
      cycle_cnt  <= cnt_d;
      stop       <= stop_d;
      hold       <= hold_d;
      cycle_wrap <= wrap_d;
      run        <= state_d == RUN;
      all_red    <= state_d == IDLE || state_d == CLEAR || state_d == HOLD;
    end
  end
endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched: scoreboard bench for intersection_sched against a behavioural model
module tb_intersection_sched;
  localparam int TD = 4;
  localparam int MH = 2;
  localparam int STOPPED = 0, ALIGN = 1, CYC = 2, EVAC = 3, HOLDING = 4;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, emergency = 1'b0;
  logic tick, run, all_red, cycle_wrap;
  logic [6:0] cycle_cnt;
  intersection_sched #(.TICK_DIV(TD), .MAINT_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .emergency(emergency),
    .tick(tick), .run(run), .all_red(all_red), .cycle_cnt(cycle_cnt), .cycle_wrap(cycle_wrap)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic tick;
    logic run;
    logic all_red;
    logic [6:0] cnt;
    logic wrap;
  } exp_t;
  exp_t sb[$];
  exp_t e, got;
  int checks = 0, failures = 0;
  bit started = 0;
  int m_mode, m_pos, m_left, m_pre;
  bit m_tick, m_armed, m_wrap;
  function automatic exp_t m_out();
    exp_t r;
    r.tick = m_tick;
    r.run = m_mode == CYC;
    r.all_red = m_mode == STOPPED || m_mode == EVAC || m_mode == HOLDING;
    r.cnt = 7'(m_pos);
    r.wrap = m_wrap;
    return r;
  endfunction
  // Reference model: one step per clk, expectations queued for the monitor
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = STOPPED; m_pos = 0; m_left = 0; m_pre = 0;
      m_tick = 0; m_armed = 0; m_wrap = 0;
      sb.delete();
    end else begin
      m_wrap = 0;
      if (emergency) begin
        m_mode = EVAC; m_pos = 0; m_armed = 0;
      end else if (m_mode == EVAC) begin
        m_mode = HOLDING; m_left = MH;
      end else if (m_tick) begin
        if (m_mode == STOPPED && enable) m_mode = ALIGN;
        else if (m_mode == ALIGN) begin
          m_mode = CYC; m_pos = 1;
        end else if (m_mode == CYC) begin
          if (m_pos == 68 && m_armed && !enable) begin
            m_mode = STOPPED; m_pos = 0; m_armed = 0;
          end else begin
            m_wrap = m_pos == 68;
            m_pos = m_pos % 68 + 1;
            m_armed = !enable;
          end
        end else if (m_mode == HOLDING) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = enable ? ALIGN : STOPPED;
        end
      end
      m_pre = (m_pre + 1) % TD;
      m_tick = m_pre == TD - 1;
    end
    sb.push_back(m_out());
    started = 1;
  end
  // Monitor: compares DUT outputs with the queued expectation on the falling edge
  always @(negedge clk) begin
    if (started) begin
      checks++;
      got = {tick, run, all_red, cycle_cnt, cycle_wrap};
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got tick=%b run=%b all_red=%b cnt=%0d wrap=%b want tick=%b run=%b all_red=%b cnt=%0d wrap=%b",
                   $time, got.tick, got.run, got.all_red, got.cnt, got.wrap, e.tick, e.run, e.all_red, e.cnt, e.wrap);
        end
      end
    end
  end
  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_for(input int mode, input int pos, input int bound, input string name);
    int i = 0;
    while (!(m_mode == mode && (pos < 0 || m_pos == pos)) && i < bound) begin
      clks(1);
      i++;
    end
    checks++;
    if (i >= bound) begin
      failures++;
      $display("FAIL wait_%s timed out after %0d clks (mode=%0d pos=%0d)", name, bound, m_mode, m_pos);
    end
  endtask
  initial begin
    clks(3);
    rst = 0;
    enable = 1;
    wait_for(CYC, 68, 400, "first68");
    wait_for(CYC, 1, 10, "wrap");
    wait_for(CYC, 30, 400, "stop30");
    enable = 0;
    wait_for(STOPPED, -1, 400, "graceful_stop");
    clks(8);
    enable = 1;
    wait_for(CYC, 30, 400, "cancel30");
    enable = 0;
    wait_for(CYC, 40, 100, "cancel40");
    enable = 1;
    wait_for(CYC, 1, 200, "cancel_wrap");
    wait_for(CYC, 50, 400, "emerg50");
    clks(1);
    emergency = 1;
    clks(5);
    emergency = 0;
    clks(5);
    emergency = 1;
    clks(3);
    emergency = 0;
    wait_for(CYC, 1, 100, "recover");
    wait_for(CYC, 10, 100, "rst10");
    @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if ({tick, run, all_red, cycle_cnt, cycle_wrap} !== {1'b0, 1'b0, 1'b1, 7'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got tick=%b run=%b all_red=%b cnt=%0d wrap=%b want 0 0 1 0 0",
               tick, run, all_red, cycle_cnt, cycle_wrap);
    end
    @(posedge clk);
    #3 rst = 0;
    clks(20);
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if (emergency) begin
        if ($urandom_range(0, 9) == 0) emergency = 0;
      end else if ($urandom_range(0, 599) == 0) emergency = 1;
      clks(1);
    end
    emergency = 0;
    clks(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
